// File: rtl/bist_misr_ora.sv
// ---------------------------------------------------------------------------
// bist_misr_ora
// Output response analyzer for the SPI BIST path. Compacts each response
// word from the circuit under test into an 8-bit MISR (polynomial
// x^8+x^6+x^5+x^4+1, same as the pattern generator). After PATTERN_COUNT
// responses the signature is compared with GOLDEN_SIG and done/pass are
// reported to the BIST controller.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous, active-high; returns to IDLE
//   start       in   single-cycle run request (honoured in IDLE and DONE)
//   abort       in   synchronous run cancel; beats start and resp_valid
//   resp_valid  in   resp_data holds a valid response this cycle
//   resp_data   in   [WIDTH-1:0] response word
//   busy        out  high in RUN and CHECK
//   done        out  high in DONE
//   pass        out  signature matched GOLDEN_SIG (valid while done=1)
//   signature   out  [WIDTH-1:0] live MISR register
//   resp_count  out  [7:0] responses compacted in the current run
// ---------------------------------------------------------------------------
module bist_misr_ora #(
    parameter int               WIDTH         = 8,
    parameter int               PATTERN_COUNT = 255,
    parameter logic [WIDTH-1:0] MISR_SEED     = 8'h00,
    parameter logic [WIDTH-1:0] GOLDEN_SIG    = 8'h00
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] resp_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature,
    output logic [7:0]       resp_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Count value at which the incoming response is the last one of a run.
    localparam logic [7:0] LAST_CNT = 8'(PATTERN_COUNT - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sig_q, sig_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;

    // One MISR step: shift left with feedback from taps 7,5,4,3, then fold
    // in the response word.
    function automatic logic [WIDTH-1:0] misr_next(input logic [WIDTH-1:0] s,
                                                   input logic [WIDTH-1:0] d);
        logic fb;
        fb = s[7] ^ s[5] ^ s[4] ^ s[3];
        return {s[6:0], fb} ^ d;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sig_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;

        if (abort) begin
            // Signature and count are left alone so they can be inspected.
            state_d = IDLE;
            pass_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        sig_d   = MISR_SEED;
                        cnt_d   = '0;
                        pass_d  = 1'b0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (resp_valid) begin
                        sig_d = misr_next(sig_q, resp_data);
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_q == LAST_CNT) begin
                            state_d = CHECK;
                        end
                    end
                end
                CHECK: begin
                    pass_d  = (sig_q == GOLDEN_SIG);
                    state_d = DONE;
                end
                default: state_d = IDLE;
            endcase
        end

        // Status flags are registered copies of the next state so they
        // change on the same edge as the state itself.
        busy_d = (state_d == RUN) || (state_d == CHECK);
        done_d = (state_d == DONE);
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign signature  = sig_q;
    assign resp_count = cnt_q;

endmodule

// File: tb/tb_bist_misr_ora.sv
// ---------------------------------------------------------------------------
// tb_bist_misr_ora
// Self-checking bench for bist_misr_ora. Four instances share one stimulus:
//   u_pass  PATTERN_COUNT=2, seed 0x00, golden 0x02 (scoreboarded)
//   u_fail  PATTERN_COUNT=2, seed 0x00, golden 0x03
//   u_fb1   PATTERN_COUNT=1, seed 0xB8
//   u_fb2   PATTERN_COUNT=1, seed 0x80
// ---------------------------------------------------------------------------
module tb_bist_misr_ora;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       resp_valid = 1'b0;
    logic [7:0] resp_data = 8'h00;

    logic       p_busy, p_done, p_pass;
    logic [7:0] p_sig, p_cnt;
    logic       f_busy, f_done, f_pass;
    logic [7:0] f_sig, f_cnt;
    logic       b1_busy, b1_done, b1_pass;
    logic [7:0] b1_sig, b1_cnt;
    logic       b2_busy, b2_done, b2_pass;
    logic [7:0] b2_sig, b2_cnt;

    always #5 clk = ~clk;

    bist_misr_ora #(.WIDTH(8), .PATTERN_COUNT(2), .MISR_SEED(8'h00), .GOLDEN_SIG(8'h02)) u_pass (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .busy(p_busy), .done(p_done), .pass(p_pass),
        .signature(p_sig), .resp_count(p_cnt));

    bist_misr_ora #(.WIDTH(8), .PATTERN_COUNT(2), .MISR_SEED(8'h00), .GOLDEN_SIG(8'h03)) u_fail (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .busy(f_busy), .done(f_done), .pass(f_pass),
        .signature(f_sig), .resp_count(f_cnt));

    bist_misr_ora #(.WIDTH(8), .PATTERN_COUNT(1), .MISR_SEED(8'hB8), .GOLDEN_SIG(8'h00)) u_fb1 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .busy(b1_busy), .done(b1_done), .pass(b1_pass),
        .signature(b1_sig), .resp_count(b1_cnt));

    bist_misr_ora #(.WIDTH(8), .PATTERN_COUNT(1), .MISR_SEED(8'h80), .GOLDEN_SIG(8'h00)) u_fb2 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .busy(b2_busy), .done(b2_done), .pass(b2_pass),
        .signature(b2_sig), .resp_count(b2_cnt));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference MISR step for x^8+x^6+x^5+x^4+1 (taps 7,5,4,3).
    function automatic logic [7:0] ref_step(input logic [7:0] s, input logic [7:0] d);
        return {s[6:0], ^(s & 8'hB8)} ^ d;
    endfunction

    // Scoreboard queues for u_pass: per-sample signature and end-of-run result.
    logic [7:0] exp_sig_q[$];
    logic       exp_pass_q[$];
    logic [7:0] exp_fsig_q[$];

    // Model of u_pass run state.
    logic       m_run = 1'b0;
    logic [7:0] m_sig = 8'h00;
    int         m_cnt = 0;

    task automatic sample(input logic [7:0] d);
        resp_valid = 1'b1;
        resp_data  = d;
        if (m_run) begin
            m_sig = ref_step(m_sig, d);
            m_cnt++;
            exp_sig_q.push_back(m_sig);
            if (m_cnt == 2) begin
                m_run = 1'b0;
                exp_pass_q.push_back(m_sig == 8'h02);
                exp_fsig_q.push_back(m_sig);
            end
        end
        @(negedge clk);
        resp_valid = 1'b0;
        resp_data  = 8'h00;
    endtask

    task automatic do_start();
        start = 1'b1;
        if (!m_run) begin
            m_run = 1'b1;
            m_sig = 8'h00;
            m_cnt = 0;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        m_run = 1'b0;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: each count increment pops an expected signature, each rising
    // done pops an expected result.
    logic [7:0] prev_cnt  = 8'h00;
    logic       prev_done = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            if (p_cnt == prev_cnt + 8'd1) begin
                if (exp_sig_q.size() == 0) check("sb_unexp_count", p_cnt, prev_cnt);
                else check("sb_sig", p_sig, exp_sig_q.pop_front());
            end
            if (p_done && !prev_done) begin
                if (exp_pass_q.size() == 0) begin
                    check("sb_unexp_done", p_done, 1'b0);
                end else begin
                    check("sb_pass", p_pass, exp_pass_q.pop_front());
                    check("sb_final_sig", p_sig, exp_fsig_q.pop_front());
                    check("sb_busy_at_done", p_busy, 1'b0);
                end
            end
        end
        prev_cnt  <= p_cnt;
        prev_done <= p_done;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle(2);
        check("rst_sig",  p_sig,  8'h00);
        check("rst_cnt",  p_cnt,  8'h00);
        check("rst_busy", p_busy, 1'b0);
        check("rst_done", p_done, 1'b0);
        check("rst_pass", p_pass, 1'b0);
        reset = 1'b0;
        idle(1);

        // Feedback: PATTERN_COUNT=1 instances with data 0x00.
        do_start();
        sample(8'h00);
        check("fb1_busy_latency", b1_busy, 1'b1);
        check("fb1_done_latency", b1_done, 1'b0);
        check("fb1_sig", b1_sig, 8'h70);
        check("fb2_sig", b2_sig, 8'h01);
        sample(8'h00);
        check("fb1_done", b1_done, 1'b1);
        check("fb1_cnt_nowrap", b1_cnt, 8'h01);
        check("fb1_sig_hold", b1_sig, 8'h70);
        check("fb2_sig_hold", b2_sig, 8'h01);
        idle(1);
        check("zero_run_done", p_done, 1'b1);

        // Pass/fail path, started from DONE.
        do_start();
        check("start_done_clears", p_done, 1'b0);
        check("start_done_busy", p_busy, 1'b1);
        check("start_done_cnt", p_cnt, 8'h00);
        sample(8'h01);
        sample(8'h00);
        check("pass_busy_n", p_busy, 1'b1);
        check("pass_done_n", p_done, 1'b0);
        idle(1);
        check("pass_done", p_done, 1'b1);
        check("pass_pass", p_pass, 1'b1);
        check("pass_sig", p_sig, 8'h02);
        check("fail_done", f_done, 1'b1);
        check("fail_pass", f_pass, 1'b0);
        check("fail_sig", f_sig, 8'h02);

        // Abort after one sample, then a response in IDLE.
        do_start();
        sample(8'h01);
        do_abort();
        check("abort_busy", p_busy, 1'b0);
        check("abort_done", p_done, 1'b0);
        check("abort_pass", p_pass, 1'b0);
        check("abort_sig", p_sig, 8'h01);
        check("abort_cnt", p_cnt, 8'h01);
        sample(8'hFF);
        idle(1);
        check("idle_ignore_sig", p_sig, 8'h01);
        check("idle_ignore_cnt", p_cnt, 8'h01);

        // Gaps with a start pulse during RUN, then a response in DONE.
        do_start();
        sample(8'h01);
        idle(1);
        do_start();
        idle(1);
        check("gap_cnt", p_cnt, 8'h01);
        check("gap_busy", p_busy, 1'b1);
        sample(8'h00);
        idle(1);
        check("gap_done", p_done, 1'b1);
        check("gap_pass", p_pass, 1'b1);
        check("gap_sig", p_sig, 8'h02);
        check("gap_cnt_final", p_cnt, 8'h02);
        sample(8'h5A);
        idle(1);
        check("done_ignore_sig", p_sig, 8'h02);
        check("done_ignore_cnt", p_cnt, 8'h02);
        check("done_hold_pass", p_pass, 1'b1);

        // Asynchronous reset mid-run.
        do_start();
        sample(8'h01);
        #2;
        reset = 1'b1;
        m_run = 1'b0;
        #1;
        check("mid_rst_sig",  p_sig,  8'h00);
        check("mid_rst_cnt",  p_cnt,  8'h00);
        check("mid_rst_busy", p_busy, 1'b0);
        check("mid_rst_done", p_done, 1'b0);
        check("mid_rst_pass", p_pass, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        idle(1);
        do_start();
        sample(8'h01);
        sample(8'h00);
        idle(1);
        check("post_rst_sig", p_sig, 8'h02);
        check("post_rst_pass", p_pass, 1'b1);

        idle(2);
        check("sb_drain", exp_sig_q.size() + exp_pass_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
